// File: rtl/keytab_lookup_arbiter.sv
// Run-time programmable key->data table shared by two requesters. Lookups are
// granted round-robin, one per cycle, with a registered response slot per requester.
module keytab_lookup_arbiter #(
  parameter int                  NR_KEY      = 8,
  parameter int                  KEY_LEN     = 4,
  parameter int                  DATA_LEN    = 8,
  parameter int                  HAS_DEFAULT = 1,
  parameter logic [DATA_LEN-1:0] DEFAULT_OUT = '0,
  localparam int                 IDX_W       = $clog2(NR_KEY)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [KEY_LEN-1:0]  cfg_key,
  input  logic [DATA_LEN-1:0] cfg_data,
  input  logic                cfg_en,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [KEY_LEN-1:0]  req0_key,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [KEY_LEN-1:0]  req1_key,
  output logic                rsp0_valid,
  input  logic                rsp0_ready,
  output logic [DATA_LEN-1:0] rsp0_data,
  output logic                rsp0_hit,
  output logic                rsp1_valid,
  input  logic                rsp1_ready,
  output logic [DATA_LEN-1:0] rsp1_data,
  output logic                rsp1_hit
);

  typedef enum logic {RSP_EMPTY = 1'b0, RSP_FULL = 1'b1} rsp_st_e;

  logic [NR_KEY-1:0]   tab_en;
  logic [KEY_LEN-1:0]  tab_key  [NR_KEY];
  logic [DATA_LEN-1:0] tab_data [NR_KEY];

  rsp_st_e             st0, st1;
  logic                rr_ptr;
  logic                cfg_hit_range;
  logic                elig0, elig1, gnt0, gnt1;
  logic [KEY_LEN-1:0]  lk_key_p0;
  logic [DATA_LEN-1:0] lk_data_p0;
  logic                lk_hit_p0;

  assign rsp0_valid = (st0 == RSP_FULL);
  assign rsp1_valid = (st1 == RSP_FULL);

  // A full slot can still take a new grant when it is being drained this cycle.
  assign elig0 = !rst && req0_valid && (!rsp0_valid || rsp0_ready);
  assign elig1 = !rst && req1_valid && (!rsp1_valid || rsp1_ready);
  assign gnt0  = elig0 && (!elig1 || !rr_ptr);
  assign gnt1  = elig1 && (!elig0 ||  rr_ptr);

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign lk_key_p0     = gnt1 ? req1_key : req0_key;
  assign cfg_hit_range = ({1'b0, cfg_idx} < (IDX_W+1)'(NR_KEY));

  // Scan downwards so the lowest matching index is the one left standing.
  always_comb begin
    lk_hit_p0  = 1'b0;
    lk_data_p0 = (HAS_DEFAULT != 0) ? DEFAULT_OUT : '0;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (tab_en[i] && (tab_key[i] == lk_key_p0)) begin
        lk_hit_p0  = 1'b1;
        lk_data_p0 = tab_data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tab_en <= '0;
    end else if (cfg_we && cfg_hit_range) begin
      tab_en[cfg_idx] <= cfg_en;
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_we && cfg_hit_range) begin
      tab_key[cfg_idx]  <= cfg_key;
      tab_data[cfg_idx] <= cfg_data;
    end
  end

  // ---- stage p1: registered response slots and round-robin pointer ----
  always_ff @(posedge clk) begin
    if (rst) begin
      st0       <= RSP_EMPTY;
      st1       <= RSP_EMPTY;
      rsp0_data <= '0;
      rsp0_hit  <= 1'b0;
      rsp1_data <= '0;
      rsp1_hit  <= 1'b0;
      rr_ptr    <= 1'b0;
    end else begin
      if (gnt0) begin
        st0       <= RSP_FULL;
        rsp0_data <= lk_data_p0;
        rsp0_hit  <= lk_hit_p0;
      end else if (rsp0_ready) begin
        st0 <= RSP_EMPTY;
      end
      if (gnt1) begin
        st1       <= RSP_FULL;
        rsp1_data <= lk_data_p0;
        rsp1_hit  <= lk_hit_p0;
      end else if (rsp1_ready) begin
        st1 <= RSP_EMPTY;
      end
      if (gnt0) begin
        rr_ptr <= 1'b1;
      end else if (gnt1) begin
        rr_ptr <= 1'b0;
      end
    end
  end

endmodule
